spi_master_driver: RTL and testbench

- Command-level SPI master that sits directly upstream of the SPI wrapper and drives its MOSI/SS_n while sampling its MISO.
- Accepts one RAM command per transaction from a valid/ready host interface: write address, write data, read address, or read data.
- Serialises each command into the slave's frame format.
- For read-data commands, deserialises the 8-bit MISO reply and returns it on a response strobe.
- SPI runs on the system clock: no divider, and the slave samples on the same edge domain.

---
 rtl/spi_master_driver.sv | 130 +++++++++++++
 tb/tb_spi_master_driver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_driver.sv
// Command-level SPI master: takes one RAM command per host handshake,
// frames it onto MOSI/SS_n and, for read-data commands, collects the
// 8-bit MISO reply and reports it on a one-cycle response strobe.
module spi_master_driver #(
   parameter int RD_WAIT  = 2,
   parameter int IDLE_GAP = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       MOSI,
   input  logic       MISO,
   output logic       SS_n
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEL   = 3'd1,
      SHIFT = 3'd2,
      WAIT  = 3'd3,
      RECV  = 3'd4,
      GAP   = 3'd5
   } state_t;

   // Counter reload values: each counter counts down to zero inclusive
   localparam logic [3:0] WAIT_LD = 4'(RD_WAIT - 1);
   localparam logic [3:0] GAP_LD  = 4'(IDLE_GAP - 1);

   state_t      state;
   logic [10:0] sreg;
   logic [3:0]  cnt;
   logic        rd;

   // Frame sequencer; every output is registered straight from this block
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         rd        <= 1'b0;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         SS_n      <= 1'b1;
         MOSI      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  // rw select bit is cmd_type[1], sent ahead of the type field
                  sreg      <= {cmd_type[1], cmd_type, cmd_data};
                  rd        <= &cmd_type;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  SS_n      <= 1'b0;
                  MOSI      <= 1'b0;
                  state     <= SEL;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            // Slave's command-check cycle has MOSI low; first bit goes out now
            SEL: begin
               MOSI  <= sreg[10];
               sreg  <= {sreg[9:0], 1'b0};
               cnt   <= 4'd10;
               state <= SHIFT;
            end
            SHIFT: begin
               if (cnt == 4'd0) begin
                  MOSI <= 1'b0;
                  if (rd) begin
                     cnt   <= WAIT_LD;
                     state <= WAIT;
                  end else begin
                     SS_n  <= 1'b1;
                     busy  <= 1'b0;
                     cnt   <= GAP_LD;
                     state <= GAP;
                  end
               end else begin
                  MOSI <= sreg[10];
                  sreg <= {sreg[9:0], 1'b0};
                  cnt  <= cnt - 4'd1;
               end
            end
            // Slave turnaround; MISO is not looked at here
            WAIT: begin
               if (cnt == 4'd0) begin
                  cnt   <= 4'd7;
                  state <= RECV;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            // Reply is shifted straight into rsp_data, MSB first
            RECV: begin
               rsp_data <= {rsp_data[6:0], MISO};
               if (cnt == 4'd0) begin
                  rsp_valid <= 1'b1;
                  SS_n      <= 1'b1;
                  busy      <= 1'b0;
                  cnt       <= GAP_LD;
                  state     <= GAP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            GAP: begin
               if (cnt == 4'd0) begin
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_driver.sv
// Bench for spi_master_driver: a timeline reference model predicts every
// output from the acceptance edge offset; directed table vectors, corner
// sequences and randomized commands drive the DUT.
module tb_spi_master_driver;
   localparam int RD_WAIT  = 2;
   localparam int IDLE_GAP = 1;

   logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, MISO = 1'b0;
   logic [1:0] cmd_type = 2'b00;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready, rsp_valid, busy, MOSI, SS_n;
   logic [7:0] rsp_data;

   spi_master_driver #(.RD_WAIT(RD_WAIT), .IDLE_GAP(IDLE_GAP)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // ---------------- reference model (frame timeline by edge offset) ------
   int          n = 0, t_acc = 0, j = 0, len = 0, acc_cnt = 0;
   bit          active = 0, m_rd = 0;
   logic [11:0] bits = '0;
   logic [7:0]  e_rdata = 8'h00;
   logic        e_ssn = 1, e_mosi = 0, e_busy = 0, e_rdy = 0, e_rv = 0;

   initial forever begin
      @(posedge clk);
      n++;
      e_rv = 0;
      if (!rst_n) begin
         active = 0; e_ssn = 1; e_mosi = 0; e_busy = 0; e_rdy = 0; e_rdata = 8'h00;
      end else begin
         if (!active) begin
            if (e_rdy && cmd_valid) begin
               active = 1; t_acc = n; m_rd = (cmd_type == 2'b11);
               bits = {1'b0, cmd_type[1], cmd_type, cmd_data};
               e_rdy = 0; acc_cnt++;
            end else e_rdy = 1;
         end
         if (active) begin
            j   = n - t_acc;
            len = m_rd ? 20 + RD_WAIT : 12;
            if (m_rd && j >= 13 + RD_WAIT && j <= 20 + RD_WAIT) e_rdata = {e_rdata[6:0], MISO};
            e_ssn  = (j >= len);
            e_busy = (j < len);
            e_mosi = (j < 12) ? bits[11 - j] : 1'b0;
            e_rv   = m_rd && (j == len);
            if (j == len + IDLE_GAP) begin active = 0; e_rdy = 1; end
         end
      end
   end

   // ---------------- MISO driver: pattern in the reply window, noise elsewhere
   logic [7:0] pat = 8'h00;
   initial forever begin
      int jn, idx;
      @(negedge clk);
      jn = n + 1 - t_acc;
      if (active && m_rd && jn >= 13 + RD_WAIT && jn <= 20 + RD_WAIT) begin
         idx  = 7 - (jn - (13 + RD_WAIT));
         MISO = pat[idx];
      end else MISO = 1'($urandom);
   end

   // ---------------- monitor + per-cycle compare -------------------------
   int          low_run = 0, last_low = 0, high_run = 0, min_high = 1000, rsp_cnt = 0;
   bit          prev_ssn = 1, seen_low = 0;
   logic [11:0] mosi_cap = '0;
   logic [7:0]  last_rsp = 8'h00;

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("ss_n", SS_n, e_ssn);
         chk("mosi", MOSI, e_mosi);
         chk("busy", busy, e_busy);
         chk("cmd_ready", cmd_ready, e_rdy);
         chk("rsp_valid", rsp_valid, e_rv);
         chk("rsp_data", rsp_data, e_rdata);
         if (SS_n === 1'b0) begin
            if (prev_ssn) begin
               if (seen_low && high_run < min_high) min_high = high_run;
               low_run = 0; mosi_cap = '0; seen_low = 1;
            end
            if (low_run < 12) mosi_cap = {mosi_cap[10:0], MOSI};
            low_run++;
         end else begin
            if (!prev_ssn) begin last_low = low_run; high_run = 0; end
            high_run++;
         end
         prev_ssn = (SS_n !== 1'b0);
         if (rsp_valid === 1'b1) begin rsp_cnt++; last_rsp = rsp_data; end
      end
   end

   // ---------------- stimulus helpers -------------------------------------
   task automatic send_cmd(input logic [1:0] t, input logic [7:0] d, output int waits);
      logic r;
      r = 0; waits = 0;
      cmd_type = t; cmd_data = d; cmd_valid = 1;
      for (int i = 0; i < 200; i++) begin
         r = cmd_ready;
         @(posedge clk);
         waits++;
         if (r) break;
         @(negedge clk);
      end
      @(negedge clk);
      cmd_valid = 0;
      if (!r) timeout_fail("accept");
   endtask

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1 && busy === 1'b0) done = 1;
      end
      if (!done) timeout_fail("idle");
   endtask

   typedef struct {
      logic [1:0]  t;
      logic [7:0]  d;
      logic [7:0]  miso;
      int          exp_low;
      logic [11:0] exp_mosi;
      int          exp_rsp;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int w, r0, a0;
      vecs[0] = '{2'b00, 8'hA5, 8'h00, 12, 12'h0A5, 0, 8'h00};
      vecs[1] = '{2'b00, 8'h10, 8'h00, 12, 12'h010, 0, 8'h00};
      vecs[2] = '{2'b01, 8'h3C, 8'h00, 12, 12'h13C, 0, 8'h00};
      vecs[3] = '{2'b10, 8'h10, 8'h00, 12, 12'h610, 0, 8'h00};
      vecs[4] = '{2'b11, 8'h00, 8'h3C, 22, 12'h700, 1, 8'h3C};
      vecs[5] = '{2'b11, 8'h5A, 8'h9D, 22, 12'h75A, 1, 8'h9D};
      vecs[6] = '{2'b01, 8'hFF, 8'h00, 12, 12'h1FF, 0, 8'h00};

      // reset state
      @(negedge clk);
      chk_en = 1;
      repeat (2) @(negedge clk);
      chk("rst_ss_n", SS_n, 1'b1);
      chk("rst_mosi", MOSI, 1'b0);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      rst_n = 1;

      // directed table
      foreach (vecs[i]) begin
         pat = vecs[i].miso;
         r0  = rsp_cnt;
         send_cmd(vecs[i].t, vecs[i].d, w);
         wait_idle();
         chk("vec_low", last_low, vecs[i].exp_low);
         chk("vec_mosi", mosi_cap, vecs[i].exp_mosi);
         chk("vec_rsp_cnt", rsp_cnt - r0, vecs[i].exp_rsp);
         if (vecs[i].exp_rsp != 0) chk("vec_rsp_byte", last_rsp, vecs[i].exp_byte);
      end

      // cmd_valid pulse while busy is ignored
      a0 = acc_cnt;
      send_cmd(2'b00, 8'h81, w);
      repeat (3) @(negedge clk);
      cmd_type = 2'b11; cmd_data = 8'hEE; cmd_valid = 1;
      @(negedge clk);
      chk("busy_pulse_ready", cmd_ready, 1'b0);
      cmd_valid = 0;
      wait_idle();
      chk("busy_pulse_acc", acc_cnt - a0, 1);
      chk("busy_pulse_mosi", mosi_cap, 12'h081);
      chk("busy_pulse_low", last_low, 12);

      // back-to-back: valid held for three acceptances
      a0 = acc_cnt; min_high = 1000;
      cmd_type = 2'b01; cmd_data = 8'h55; cmd_valid = 1;
      for (int i = 0; i < 200 && acc_cnt < a0 + 3; i++) @(negedge clk);
      cmd_valid = 0;
      wait_idle();
      chk("b2b_acc", acc_cnt - a0, 3);
      chk("b2b_gap_ok", 32'(min_high >= 1), 1);

      // reset at T+8 of a read-data frame
      r0 = rsp_cnt;
      pat = 8'hFF;
      send_cmd(2'b11, 8'h00, w);
      repeat (7) @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      chk("midrst_ss_n", SS_n, 1'b1);
      chk("midrst_mosi", MOSI, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_rsp_data", rsp_data, 8'h00);
      rst_n = 1;
      send_cmd(2'b01, 8'h22, w);
      chk("midrst_accept_edges", w, 2);
      wait_idle();
      chk("midrst_no_rsp", rsp_cnt - r0, 0);

      // randomized commands against the model
      for (int i = 0; i < 40; i++) begin
         logic [1:0] t;
         t   = 2'($urandom);
         pat = 8'($urandom);
         r0  = rsp_cnt;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_cmd(t, 8'($urandom), w);
         wait_idle();
         chk("rnd_rsp_cnt", rsp_cnt - r0, (t == 2'b11) ? 1 : 0);
         if (t == 2'b11) chk("rnd_rsp_byte", last_rsp, pat);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
